// File: rtl/dft_sequencer.sv
// Control sequencer for the direct-DFT datapath. It loads N samples from RAM into the cache,
// then for each bin k it runs a clear / MAC / drain / write-back pass.
module dft_sequencer #(
  parameter int ADDR_W  = 12,
  parameter int MAC_LAT = 1
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              start,
  input  logic [ADDR_W-1:0] samp_number,
  output logic              busy,
  output logic              calc_end,
  output logic              err,
  output logic              mode,
  output logic              ram_rd_en,
  output logic [ADDR_W-1:0] ram_rd_addr,
  output logic              cache_we,
  output logic [ADDR_W-1:0] cache_waddr,
  output logic [ADDR_W-1:0] n_index,
  output logic [ADDR_W-1:0] k_index,
  output logic              acc_clr,
  output logic              acc_ce,
  output logic              wb_valid,
  output logic [ADDR_W-1:0] wb_addr,
  input  logic              wb_ready
);

  typedef enum logic [2:0] {
    S_IDLE, S_LOAD, S_LFLUSH, S_CLR, S_MAC, S_DRAIN, S_WB, S_DONE
  } state_t;

  state_t              state_q, state_d;
  logic [ADDR_W-1:0]   nm1_q, nm1_d;
  logic [ADDR_W-1:0]   rd_addr_q, rd_addr_d;
  logic [ADDR_W-1:0]   n_q, n_d;
  logic [ADDR_W-1:0]   k_q, k_d;
  logic [ADDR_W-1:0]   cache_waddr_q, cache_waddr_d;
  logic                cache_we_q, cache_we_d;
  logic                err_q, err_d;
  logic [2:0]          drain_q, drain_d;
  logic [MAC_LAT-1:0]  pipe_q, pipe_d;
  logic                n_valid;

  // NOTE: every signal written here gets a default first, so no path leaves it unassigned and no latch is inferred.
  always_comb begin
    state_d       = state_q;
    nm1_d         = nm1_q;
    rd_addr_d     = rd_addr_q;
    n_d           = n_q;
    k_d           = k_q;
    drain_d       = drain_q;
    err_d         = 1'b0;
    n_valid       = (state_q == S_MAC);
    cache_we_d    = (state_q == S_LOAD);
    cache_waddr_d = rd_addr_q;
    // The product of each issued n reaches the accumulator MAC_LAT cycles later.
    pipe_d        = (pipe_q << 1) | MAC_LAT'(n_valid);

    unique case (state_q)
      S_IDLE: begin
        if (start) begin
          if (samp_number >= ADDR_W'(2)) begin
            nm1_d     = samp_number - ADDR_W'(1);
            rd_addr_d = '0;
            state_d   = S_LOAD;
          end else begin
            err_d = 1'b1;
          end
        end
      end
      S_LOAD: begin
        if (rd_addr_q == nm1_q) state_d = S_LFLUSH;
        else                    rd_addr_d = rd_addr_q + ADDR_W'(1);
      end
      S_LFLUSH: begin
        k_d     = '0;
        state_d = S_CLR;
      end
      S_CLR: begin
        n_d     = '0;
        state_d = S_MAC;
      end
      S_MAC: begin
        drain_d = '0;
        if (n_q == nm1_q) state_d = S_DRAIN;
        else              n_d = n_q + ADDR_W'(1);
      end
      S_DRAIN: begin
        if (drain_q == 3'(MAC_LAT - 1)) state_d = S_WB;
        else                            drain_d = drain_q + 3'd1;
      end
      S_WB: begin
        if (wb_ready) begin
          if (k_q == nm1_q) begin
            state_d = S_DONE;
          end else begin
            k_d     = k_q + ADDR_W'(1);
            state_d = S_CLR;
          end
        end
      end
      S_DONE:  state_d = S_IDLE;
      default: state_d = S_IDLE;
    endcase
  end

  // NOTE: state registers use non-blocking assignments so every flop samples pre-edge values.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q       <= S_IDLE;
      nm1_q         <= '0;
      rd_addr_q     <= '0;
      n_q           <= '0;
      k_q           <= '0;
      cache_waddr_q <= '0;
      cache_we_q    <= 1'b0;
      err_q         <= 1'b0;
      drain_q       <= '0;
      pipe_q        <= '0;
    end else begin
      state_q       <= state_d;
      nm1_q         <= nm1_d;
      rd_addr_q     <= rd_addr_d;
      n_q           <= n_d;
      k_q           <= k_d;
      cache_waddr_q <= cache_waddr_d;
      cache_we_q    <= cache_we_d;
      err_q         <= err_d;
      drain_q       <= drain_d;
      pipe_q        <= pipe_d;
    end
  end

  assign busy        = (state_q != S_IDLE);
  assign calc_end    = (state_q == S_DONE);
  assign err         = err_q;
  assign mode        = state_q inside {S_IDLE, S_LOAD, S_LFLUSH, S_DONE};
  assign ram_rd_en   = (state_q == S_LOAD);
  assign ram_rd_addr = rd_addr_q;
  assign cache_we    = cache_we_q;
  assign cache_waddr = cache_waddr_q;
  assign n_index     = n_q;
  assign k_index     = k_q;
  assign acc_clr     = (state_q == S_CLR);
  assign acc_ce      = pipe_q[MAC_LAT-1];
  assign wb_valid    = (state_q == S_WB);
  assign wb_addr     = k_q;

endmodule

// File: tb/tb_dft_sequencer.sv
// Directed bench for dft_sequencer: two instances (MAC_LAT = 1 and 3) share stimulus;
// each scenario observes one of them against hand-derived cycle counts and sequences.
module tb_dft_sequencer;

  localparam int AW = 12;

  logic          clk = 1'b0;
  logic          rst;
  logic          start;
  logic [AW-1:0] samp_number;
  logic          wb_ready;

  logic          busy_o [2];
  logic          calc_end_o [2];
  logic          err_o [2];
  logic          mode_o [2];
  logic          rd_en_o [2];
  logic [AW-1:0] rd_addr_o [2];
  logic          cache_we_o [2];
  logic [AW-1:0] cache_waddr_o [2];
  logic [AW-1:0] n_index_o [2];
  logic [AW-1:0] k_index_o [2];
  logic          acc_clr_o [2];
  logic          acc_ce_o [2];
  logic          wb_valid_o [2];
  logic [AW-1:0] wb_addr_o [2];

  int n_checks = 0;
  int n_fail   = 0;

  always #5 clk = ~clk;

  dft_sequencer #(.ADDR_W(AW), .MAC_LAT(1)) u_dut_lat1 (
    .clk(clk), .rst(rst), .start(start), .samp_number(samp_number),
    .busy(busy_o[0]), .calc_end(calc_end_o[0]), .err(err_o[0]), .mode(mode_o[0]),
    .ram_rd_en(rd_en_o[0]), .ram_rd_addr(rd_addr_o[0]),
    .cache_we(cache_we_o[0]), .cache_waddr(cache_waddr_o[0]),
    .n_index(n_index_o[0]), .k_index(k_index_o[0]),
    .acc_clr(acc_clr_o[0]), .acc_ce(acc_ce_o[0]),
    .wb_valid(wb_valid_o[0]), .wb_addr(wb_addr_o[0]), .wb_ready(wb_ready)
  );

  dft_sequencer #(.ADDR_W(AW), .MAC_LAT(3)) u_dut_lat3 (
    .clk(clk), .rst(rst), .start(start), .samp_number(samp_number),
    .busy(busy_o[1]), .calc_end(calc_end_o[1]), .err(err_o[1]), .mode(mode_o[1]),
    .ram_rd_en(rd_en_o[1]), .ram_rd_addr(rd_addr_o[1]),
    .cache_we(cache_we_o[1]), .cache_waddr(cache_waddr_o[1]),
    .n_index(n_index_o[1]), .k_index(k_index_o[1]),
    .acc_clr(acc_clr_o[1]), .acc_ce(acc_ce_o[1]),
    .wb_valid(wb_valid_o[1]), .wb_addr(wb_addr_o[1]), .wb_ready(wb_ready)
  );

  task automatic check(input string tag, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0d, expected %0d", tag, act, exp);
    end
  endtask

  task automatic wait_idle();
    bit ok;
    ok = 1'b0;
    for (int i = 0; i < 500 && !ok; i++) begin
      @(negedge clk);
      ok = !busy_o[0] && !busy_o[1];
    end
    check("idle_wait", ok, 1);
  endtask

  task automatic err_pulse(input int v);
    @(negedge clk);
    samp_number = AW'(v);
    start       = 1'b1;
    @(negedge clk);
    start = 1'b0;
    check($sformatf("err_hi_n%0d", v), err_o[0], 1);
    check($sformatf("err_busy_n%0d", v), busy_o[0], 0);
    @(negedge clk);
    check($sformatf("err_lo_n%0d", v), err_o[0], 0);
    check($sformatf("err_busy2_n%0d", v), busy_o[0], 0);
  endtask

  // Runs one transform on the shared inputs and scores instance s cycle by cycle.
  task automatic run_xform(input int s, input int nn, input int lat, input int stall_k,
                           input int stall_len, input int inject_cyc, input string name);
    int cyc, busy_cnt, end_cnt, end_cyc, mode0, rd_cnt, last_rd, addr_err, wr_cnt, lag_err;
    int clr_cnt, clr_cyc, bursts, burst_len, rise_err, burst_err, overlap_err;
    int wb_cnt, wb_err, stall_vcyc, stall_act_err, stall_left, exp_busy;
    bit prev_rd_en, prev_ce, stalled, done;
    logic [AW-1:0] prev_rd_addr;
    cyc = 0; busy_cnt = 0; end_cnt = 0; end_cyc = 0; mode0 = 0; rd_cnt = 0; last_rd = 0;
    addr_err = 0; wr_cnt = 0; lag_err = 0; clr_cnt = 0; clr_cyc = 0; bursts = 0;
    burst_len = 0; rise_err = 0; burst_err = 0; overlap_err = 0; wb_cnt = 0; wb_err = 0;
    stall_vcyc = 0; stall_act_err = 0; stall_left = 0;
    prev_rd_en = 0; prev_ce = 0; stalled = 0; done = 0; prev_rd_addr = '0;

    @(negedge clk);
    samp_number = AW'(nn);
    wb_ready    = 1'b1;
    start       = 1'b1;
    @(negedge clk);
    start = 1'b0;
    while (!done && cyc < 2000) begin
      cyc++;
      if (!busy_o[s]) begin
        done = 1;
      end else begin
        busy_cnt++;
        if (calc_end_o[s]) begin end_cnt++; end_cyc = busy_cnt; end
        if (!mode_o[s]) mode0++;
        if (rd_en_o[s]) begin
          if (rd_addr_o[s] != AW'(rd_cnt)) addr_err++;
          rd_cnt++;
          last_rd = cyc;
        end
        if (cache_we_o[s] != prev_rd_en || (cache_we_o[s] && cache_waddr_o[s] != prev_rd_addr))
          lag_err++;
        if (cache_we_o[s]) wr_cnt++;
        if (acc_clr_o[s]) begin
          clr_cnt++;
          clr_cyc = cyc;
          if (acc_ce_o[s]) overlap_err++;
        end
        if (acc_ce_o[s]) begin
          if (!prev_ce && (cyc - clr_cyc) != lat + 1) rise_err++;
          burst_len++;
        end else if (prev_ce) begin
          bursts++;
          if (burst_len != nn) burst_err++;
          burst_len = 0;
        end
        if (stall_left > 0) begin
          stall_left--;
          if (stall_left == 0) wb_ready = 1'b1;
        end else if (wb_valid_o[s] && k_index_o[s] == AW'(stall_k) && !stalled && stall_len > 0) begin
          stalled    = 1;
          stall_left = stall_len;
          wb_ready   = 1'b0;
        end
        if (wb_valid_o[s]) begin
          if (wb_addr_o[s] != AW'(wb_cnt) || k_index_o[s] != AW'(wb_cnt)) wb_err++;
          if (acc_ce_o[s] || acc_clr_o[s]) stall_act_err++;
          if (k_index_o[s] == AW'(stall_k)) stall_vcyc++;
          if (wb_ready) wb_cnt++;
        end
        prev_rd_en   = rd_en_o[s];
        prev_rd_addr = rd_addr_o[s];
        prev_ce      = acc_ce_o[s];
        if (cyc == inject_cyc) begin
          start       = 1'b1;
          samp_number = AW'(2);
        end else begin
          start = 1'b0;
        end
        @(negedge clk);
      end
    end
    start    = 1'b0;
    wb_ready = 1'b1;

    exp_busy = (nn + 1) + nn * (nn + lat + 2) + 1 + stall_len;
    check({name, "_timeout"},   done, 1);
    check({name, "_busy_len"},  busy_cnt, exp_busy);
    check({name, "_end_cnt"},   end_cnt, 1);
    check({name, "_end_cyc"},   end_cyc, exp_busy);
    check({name, "_mode0"},     mode0, nn * (nn + lat + 2) + stall_len);
    check({name, "_rd_cnt"},    rd_cnt, nn);
    check({name, "_rd_last"},   last_rd, nn);
    check({name, "_rd_addr"},   addr_err, 0);
    check({name, "_wr_cnt"},    wr_cnt, nn);
    check({name, "_wr_lag"},    lag_err, 0);
    check({name, "_clr_cnt"},   clr_cnt, nn);
    check({name, "_bursts"},    bursts, nn);
    check({name, "_burst_len"}, burst_err, 0);
    check({name, "_ce_rise"},   rise_err, 0);
    check({name, "_clr_ce"},    overlap_err, 0);
    check({name, "_wb_cnt"},    wb_cnt, nn);
    check({name, "_wb_addr"},   wb_err, 0);
    check({name, "_wb_quiet"},  stall_act_err, 0);
    check({name, "_wb_hold"},   stall_vcyc, stall_len + 1);
  endtask

  initial begin
    bit found;
    rst         = 1'b1;
    start       = 1'b0;
    samp_number = '0;
    wb_ready    = 1'b1;
    repeat (2) @(negedge clk);
    check("rst_busy",  busy_o[0], 0);
    check("rst_mode",  mode_o[0], 1);
    check("rst_rd_en", rd_en_o[0], 0);
    check("rst_ce",    acc_ce_o[0], 0);
    check("rst_wbv",   wb_valid_o[0], 0);
    check("rst_k",     k_index_o[0], 0);
    rst = 1'b0;

    run_xform(0, 4, 1, 0, 0, 0, "n4");
    wait_idle();

    err_pulse(1);
    err_pulse(0);

    run_xform(0, 3, 1, 1, 5, 0, "n3_stall");
    wait_idle();

    run_xform(0, 4, 1, 0, 0, 10, "n4_inject");
    wait_idle();

    run_xform(1, 5, 3, 0, 0, 0, "n5_lat3");
    wait_idle();

    // Reset in the middle of bin 2's MAC pass, then a fresh short transform.
    @(negedge clk);
    samp_number = AW'(4);
    start       = 1'b1;
    @(negedge clk);
    start = 1'b0;
    found = 1'b0;
    for (int i = 0; i < 200 && !found; i++) begin
      if (k_index_o[0] == AW'(2) && n_index_o[0] == AW'(1)) found = 1'b1;
      else @(negedge clk);
    end
    check("mid_found", found, 1);
    rst = 1'b1;
    #1;
    check("mid_busy",   busy_o[0], 0);
    check("mid_mode",   mode_o[0], 1);
    check("mid_ce",     acc_ce_o[0], 0);
    check("mid_clr",    acc_clr_o[0], 0);
    check("mid_wbv",    wb_valid_o[0], 0);
    check("mid_n",      n_index_o[0], 0);
    check("mid_k",      k_index_o[0], 0);
    check("mid_rdaddr", rd_addr_o[0], 0);
    @(negedge clk);
    rst = 1'b0;
    run_xform(0, 2, 1, 0, 0, 0, "after_rst");
    wait_idle();

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
